// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory read channel.
//
// Carries the request/valid handshake between the fetch sequencer
// (master) and instruction memory (slave).
//   req   master -> slave  read request, held until valid
//   addr  master -> slave  read address, stable while req is high
//   valid slave -> master  rdata is valid this cycle
//   rdata slave -> master  read data
interface fetch_sequencer_if #(
    parameter int IW = 9,
    parameter int AW = 8
);
    logic          req;
    logic [AW-1:0] addr;
    logic          valid;
    logic [IW-1:0] rdata;

    modport master (output req, output addr, input valid, input rdata);
    modport slave  (input req, input addr, output valid, output rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-side controller for a simple program counter.
//
// Reads instruction memory at the current PC, waits out variable read
// latency, latches the word, decodes branch/halt and releases the PC
// for exactly one cycle per executed instruction.
//
// Ports:
//   clk, reset   clock; synchronous active-high reset
//   pc_addr      current PC from the program counter
//   pc_halt      1 = PC holds; 0 = PC updates at this edge
//   pc_branch    1 = PC loads pc + pc_offset instead of pc + 1
//   pc_offset    sign-extended branch displacement
//   imem         instruction-memory read channel (master side)
//   zero_flag    condition flag from execute, used by BRZ
//   instr        latched instruction register
//   instr_valid  one-cycle strobe while instr executes
//   done         sticky, a HALT has executed
//   fetch_err    sticky, memory did not answer within MAX_WAIT cycles
//
// state | meaning
// IDLE  | post-reset, PC held, about to start the first fetch
// FETCH | imem_req high at pc_addr, waiting for imem_valid
// EXEC  | one cycle, instr_valid high, PC released unless HALT
// STOP  | halted or fetch error; only reset leaves
module fetch_sequencer #(
    parameter int IW       = 9,
    parameter int AW       = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [AW-1:0]          pc_addr,
    output logic                   pc_halt,
    output logic                   pc_branch,
    output logic [AW-1:0]          pc_offset,
    fetch_sequencer_if.master      imem,
    input  logic                   zero_flag,
    output logic [IW-1:0]          instr,
    output logic                   instr_valid,
    output logic                   done,
    output logic                   fetch_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    // Down-counter is loaded outside FETCH; terminal count on the
    // MAX_WAIT-th cycle without valid.
    localparam logic [CW-1:0] WAIT_LOAD = CW'(MAX_WAIT - 1);

    localparam logic [2:0] OP_BR   = 3'b110;
    localparam logic [2:0] OP_BRZ  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, STOP} state_t;

    state_t         state, state_nxt;
    logic [IW-1:0]  ir, ir_nxt;
    logic [CW-1:0]  wait_cnt, wait_nxt;
    logic           done_nxt, err_nxt;

    logic [2:0]     opcode;
    logic [AW-1:0]  imm_sext;

    assign opcode    = ir[IW-1:IW-3];
    assign imm_sext  = {{(AW-6){ir[5]}}, ir[5:0]};
    assign imem.addr = pc_addr;
    assign instr     = ir;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ir        <= '0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            ir        <= ir_nxt;
            wait_cnt  <= wait_nxt;
            done      <= done_nxt;
            fetch_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ir_nxt      = ir;
        wait_nxt    = WAIT_LOAD;
        done_nxt    = done;
        err_nxt     = fetch_err;
        pc_halt     = 1'b1;
        pc_branch   = 1'b0;
        pc_offset   = '0;
        imem.req    = 1'b0;
        instr_valid = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem.req = 1'b1;
                if (imem.valid) begin
                    ir_nxt    = imem.rdata;
                    state_nxt = EXEC;
                end else if (wait_cnt == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = STOP;
                end else begin
                    wait_nxt = wait_cnt - CW'(1);
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                state_nxt   = FETCH;
                pc_halt     = 1'b0;
                case (opcode)
                    OP_BR: begin
                        pc_branch = 1'b1;
                        pc_offset = imm_sext;
                    end
                    OP_BRZ: begin
                        pc_branch = zero_flag;
                        pc_offset = imm_sext;
                    end
                    OP_HALT: begin
                        // Only the all-ones immediate halts; other 111
                        // encodings fall through as plain instructions.
                        if (ir[5:0] == 6'h3F) begin
                            pc_halt   = 1'b1;
                            done_nxt  = 1'b1;
                            state_nxt = STOP;
                        end
                    end
                    default: ;
                endcase
            end
            STOP: ;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
